// File: rtl/block_control_unit_if.sv
// block_control_unit_if: decode inputs and control/micro-op outputs of the ID-stage control unit
interface block_control_unit_if #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int OFS_W     = 32
);
  logic                 valid_in;
  logic                 freeze;
  logic [1:0]           mode;
  logic [3:0]           op_code;
  logic                 s_in;
  logic                 blk;
  logic                 up;
  logic [NUM_REGS-1:0]  reg_list;
  logic                 MEM_r_en;
  logic                 MEM_w_en;
  logic                 WB_en;
  logic                 b;
  logic                 s_out;
  logic [3:0]           exec_cmd;
  logic                 busy;
  logic [REG_IDX_W-1:0] uop_reg;
  logic [OFS_W-1:0]     uop_offset;
  logic                 uop_valid;
  logic                 last_uop;
  modport master (
    output valid_in, freeze, mode, op_code, s_in, blk, up, reg_list,
    input  MEM_r_en, MEM_w_en, WB_en, b, s_out, exec_cmd, busy, uop_reg, uop_offset, uop_valid, last_uop
  );
  modport slave (
    input  valid_in, freeze, mode, op_code, s_in, blk, up, reg_list,
    output MEM_r_en, MEM_w_en, WB_en, b, s_out, exec_cmd, busy, uop_reg, uop_offset, uop_valid, last_uop
  );
endinterface

// File: rtl/block_control_unit.sv
// block_control_unit: ID-stage decode with LDM/STM block-transfer micro-op sequencing
module block_control_unit #(
  parameter int NUM_REGS   = 16,
  parameter int REG_IDX_W  = 4,
  parameter int WORD_BYTES = 4,
  parameter int OFS_W      = 32
) (
  input logic clk,
  input logic rst,
  block_control_unit_if.slave bus
);
  localparam logic [1:0] ARITHMATIC = 2'b00, MEMORY = 2'b01, BRANCH = 2'b10;
  localparam logic [3:0] NOP_ALU_CMD = 4'b0000, MOV_CMD = 4'b0001, ADD_CMD = 4'b0010, ADC_CMD = 4'b0011,
                         SUB_CMD = 4'b0100, SBC_CMD = 4'b0101, AND_CMD = 4'b0110, ORR_CMD = 4'b0111,
                         EOR_CMD = 4'b1000, MVN_CMD = 4'b1001;
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, nxt;
  logic [NUM_REGS-1:0]  pend, low;
  logic [OFS_W-1:0]     ofs;
  logic [REG_IDX_W-1:0] idx;
  logic                 ld, upd, one, accept;
  assign low = pend & (~pend + NUM_REGS'(1));
  assign one = (pend & (pend - NUM_REGS'(1))) == '0;
  // index of the lowest pending register; the downward scan leaves the lowest set bit last
  always_comb begin
    idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) if (pend[i]) idx = REG_IDX_W'(i);
  end
  // next state and all control outputs; reset low forces every output to its idle value
  always_comb begin
    nxt = state;
    accept = 1'b0;
    bus.MEM_r_en = 1'b0;
    bus.MEM_w_en = 1'b0;
    bus.WB_en = 1'b0;
    bus.b = 1'b0;
    bus.s_out = 1'b0;
    bus.exec_cmd = NOP_ALU_CMD;
    bus.busy = 1'b0;
    bus.uop_reg = '0;
    bus.uop_offset = '0;
    bus.uop_valid = 1'b0;
    bus.last_uop = 1'b0;
    if (rst && state == XFER) begin
      bus.uop_valid = 1'b1;
      bus.uop_reg = idx;
      bus.uop_offset = ofs;
      bus.exec_cmd = upd ? ADD_CMD : SUB_CMD;
      bus.MEM_r_en = ld;
      bus.WB_en = ld;
      bus.MEM_w_en = !ld;
      bus.last_uop = one;
      bus.busy = !one;
      nxt = (!bus.freeze && one) ? IDLE : XFER;
    end else if (rst && bus.valid_in) begin
      if (bus.mode == MEMORY && bus.blk) begin
        bus.busy = |bus.reg_list;
        accept = |bus.reg_list && !bus.freeze;
        nxt = accept ? XFER : IDLE;
      end else if (bus.mode == MEMORY) begin
        bus.MEM_r_en = bus.s_in;
        bus.MEM_w_en = !bus.s_in;
        bus.WB_en = bus.s_in;
        bus.exec_cmd = ADD_CMD;
        bus.s_out = bus.s_in;
      end else if (bus.mode == BRANCH) begin
        bus.b = 1'b1;
        bus.s_out = bus.s_in;
      end else if (bus.mode == ARITHMATIC) begin
        case (bus.op_code)
          4'b1101: {bus.WB_en, bus.exec_cmd} = {1'b1, MOV_CMD};
          4'b1111: {bus.WB_en, bus.exec_cmd} = {1'b1, MVN_CMD};
          4'b0100: {bus.WB_en, bus.exec_cmd} = {1'b1, ADD_CMD};
          4'b0101: {bus.WB_en, bus.exec_cmd} = {1'b1, ADC_CMD};
          4'b0010: {bus.WB_en, bus.exec_cmd} = {1'b1, SUB_CMD};
          4'b0110: {bus.WB_en, bus.exec_cmd} = {1'b1, SBC_CMD};
          4'b0000: {bus.WB_en, bus.exec_cmd} = {1'b1, AND_CMD};
          4'b1100: {bus.WB_en, bus.exec_cmd} = {1'b1, ORR_CMD};
          4'b0001: {bus.WB_en, bus.exec_cmd} = {1'b1, EOR_CMD};
          4'b1010: {bus.WB_en, bus.exec_cmd} = {1'b0, SUB_CMD};
          4'b1000: {bus.WB_en, bus.exec_cmd} = {1'b0, AND_CMD};
          default: {bus.WB_en, bus.exec_cmd} = {1'b0, NOP_ALU_CMD};
        endcase
        bus.s_out = bus.s_in && bus.exec_cmd != NOP_ALU_CMD;
      end
    end
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  // block sequencer: latch list/direction on accept, retire one register per unfrozen cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pend <= '0;
      ofs <= '0;
      ld <= 1'b0;
      upd <= 1'b0;
    end else if (accept) begin
      pend <= bus.reg_list;
      ofs <= '0;
      ld <= bus.s_in;
      upd <= bus.up;
    end else if (state == XFER && !bus.freeze) begin
      pend <= pend & ~low;
      ofs <= ofs + OFS_W'(WORD_BYTES);
    end
endmodule

// File: tb/tb_block_control_unit.sv
// tb_block_control_unit: directed checks of legacy decode and block-transfer sequencing
module tb_block_control_unit;
  localparam logic [3:0] NOP = 4'b0000, ADD = 4'b0010, SUB = 4'b0100;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  logic [8:0] ctl;
  logic [3:0] op_t  [11] = '{4'b1101, 4'b1111, 4'b0100, 4'b0101, 4'b0010, 4'b0110, 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000};
  logic [3:0] cmd_t [11] = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b0100, 4'b0110};
  logic       wb_t  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  int         reg_t [3]  = '{0, 2, 7};
  block_control_unit_if bi ();
  block_control_unit dut (.clk(clk), .rst(rst), .bus(bi));
  always #5 clk = ~clk;
  assign ctl = {bi.MEM_r_en, bi.MEM_w_en, bi.WB_en, bi.b, bi.s_out, bi.exec_cmd};
  function automatic logic [8:0] e(input logic r, w, wb, bb, s, input logic [3:0] c);
    return {r, w, wb, bb, s, c};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op, input logic s, bk, u, input logic [15:0] rl);
    bi.valid_in = v; bi.mode = m; bi.op_code = op; bi.s_in = s; bi.blk = bk; bi.up = u; bi.reg_list = rl;
  endtask
  initial begin
    bi.freeze = 1'b0;
    drive(1, 2'b00, 4'b0100, 1, 0, 0, 16'h0000);
    #3;
    chk("reset_ctl", ctl, e(0, 0, 0, 0, 0, NOP));
    chk("reset_busy", {bi.busy, bi.uop_valid, bi.last_uop}, 0);
    #9 rst = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) begin
      drive(1, 2'b00, op_t[i], 1, 0, 0, 16'h0000);
      #1;
      chk($sformatf("legacy_op%0d", i), ctl, e(0, 0, wb_t[i], 0, 1, cmd_t[i]));
      chk($sformatf("legacy_busy%0d", i), {bi.busy, bi.uop_valid}, 0);
    end
    drive(1, 2'b01, 4'b0000, 1, 0, 0, 16'h0000); #1;
    chk("ldr", ctl, e(1, 0, 1, 0, 1, ADD));
    drive(1, 2'b01, 4'b0000, 0, 0, 0, 16'h0000); #1;
    chk("str", ctl, e(0, 1, 0, 0, 0, ADD));
    drive(1, 2'b10, 4'b0000, 0, 0, 0, 16'h0000); #1;
    chk("branch_b", {bi.b, bi.MEM_r_en, bi.MEM_w_en, bi.WB_en}, 4'b1000);
    drive(1, 2'b00, 4'b0011, 0, 0, 0, 16'h0000); #1;
    chk("unknown_op", {bi.MEM_r_en, bi.MEM_w_en, bi.WB_en, bi.b, bi.exec_cmd}, 0);
    drive(0, 2'b00, 4'b0100, 1, 0, 0, 16'h0000); #1;
    chk("invalid", {bi.MEM_r_en, bi.MEM_w_en, bi.WB_en, bi.b, bi.s_out}, 0);
    tick();
    drive(1, 2'b01, 4'b0000, 1, 1, 1, 16'h0085); #1;
    chk("ldm_accept_ctl", ctl, e(0, 0, 0, 0, 0, NOP));
    chk("ldm_accept_busy", {bi.busy, bi.uop_valid}, 2'b10);
    tick();
    drive(1, 2'b00, 4'b0100, 1, 0, 0, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("ldm_reg%0d", k), bi.uop_reg, reg_t[k]);
      chk($sformatf("ldm_ofs%0d", k), bi.uop_offset, 4 * k);
      chk($sformatf("ldm_ctl%0d", k), ctl, e(1, 0, 1, 0, 0, ADD));
      chk($sformatf("ldm_flags%0d", k), {bi.uop_valid, bi.last_uop, bi.busy}, {1'b1, k == 2, k != 2});
      tick();
    end
    #1;
    chk("after_ldm_add", ctl, e(0, 0, 1, 0, 1, ADD));
    chk("after_ldm_idle", {bi.busy, bi.uop_valid}, 0);
    drive(1, 2'b01, 4'b0000, 0, 1, 0, 16'hC000); #1;
    chk("stm_accept_busy", bi.busy, 1);
    tick();
    bi.freeze = 1'b1;
    drive(0, 2'b00, 4'b0000, 0, 0, 0, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) bi.freeze = 1'b0;
      #1;
      chk($sformatf("stm_hold_reg%0d", k), {bi.uop_reg, bi.uop_offset}, {4'd14, 32'd0});
      chk($sformatf("stm_hold_ctl%0d", k), ctl, e(0, 1, 0, 0, 0, SUB));
      chk($sformatf("stm_hold_busy%0d", k), {bi.busy, bi.last_uop}, 2'b10);
      tick();
    end
    #1;
    chk("stm_last_reg", {bi.uop_reg, bi.uop_offset}, {4'd15, 32'd4});
    chk("stm_last_ctl", ctl, e(0, 1, 0, 0, 0, SUB));
    chk("stm_last_flags", {bi.uop_valid, bi.last_uop, bi.busy}, 3'b110);
    tick();
    chk("stm_done", bi.uop_valid, 0);
    drive(1, 2'b01, 4'b0000, 1, 1, 1, 16'h0000); #1;
    chk("empty_ctl", ctl, e(0, 0, 0, 0, 0, NOP));
    chk("empty_busy", bi.busy, 0);
    tick();
    chk("empty_no_xfer", {bi.uop_valid, bi.busy}, 0);
    drive(1, 2'b01, 4'b0000, 1, 1, 1, 16'hFFFF); #1;
    chk("rst_accept", bi.busy, 1);
    tick();
    drive(0, 2'b00, 4'b0000, 0, 0, 0, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rst_blk_reg%0d", k), {bi.uop_reg, bi.uop_offset}, {4'(k), 32'(4 * k)});
      tick();
    end
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_ctl", ctl, e(0, 0, 0, 0, 0, NOP));
    chk("rst_mid_uop", {bi.busy, bi.uop_valid, bi.last_uop, bi.uop_reg, bi.uop_offset}, 0);
    #10 rst = 1'b1;
    tick();
    drive(1, 2'b00, 4'b0100, 0, 0, 0, 16'h0000); #1;
    chk("post_rst_add", ctl, e(0, 0, 1, 0, 0, ADD));
    chk("post_rst_idle", {bi.busy, bi.uop_valid}, 0);
    tick();
    chk("post_rst_still_idle", bi.uop_valid, 0);
    drive(1, 2'b01, 4'b0000, 0, 1, 1, 16'hFFFF); #1;
    chk("full_accept", bi.busy, 1);
    tick();
    drive(0, 2'b00, 4'b0000, 0, 0, 0, 16'h0000);
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("full_uop%0d", k), {bi.uop_reg, bi.uop_offset}, {4'(k), 32'(4 * k)});
      chk($sformatf("full_ctl%0d", k), ctl, e(0, 1, 0, 0, 0, ADD));
      chk($sformatf("full_flags%0d", k), {bi.uop_valid, bi.last_uop, bi.busy}, {1'b1, k == 15, k != 15});
      tick();
    end
    chk("full_idle", {bi.uop_valid, bi.busy}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/block_control_unit.md
# block_control_unit

Parametrised successor to the ID-stage control unit. It adds block-transfer (LDM/STM-style) sequencing on top of the single-cycle arithmetic/memory/branch decode. A block instruction is expanded into one memory micro-op per set bit of a register list, and `busy` freezes IF/ID until the last micro-op issues. It sits in the ID stage between the instruction decoder and the ID/EX pipeline register, and drives the same control fields the EX/MEM/WB stages already consume.

## Interface
- `NUM_REGS`, 16: register-list width and register-file size.
- `REG_IDX_W`, 4: register index width; must equal clog2(`NUM_REGS`).
- `WORD_BYTES`, 4: address step per transferred register.
- `OFS_W`, 32: width of `uop_offset`.

- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `valid_in`  in  1  ID holds a real instruction this cycle.
- `freeze`  in  1  hazard stall; sequencer state holds.
- `mode`  in  2  instruction class: ARITHMATIC / MEMORY / BRANCH constants.
- `op_code`  in  4  arithmetic opcode.
- `s_in`  in  1  S bit; in MEMORY mode it is the L bit (1 = load).
- `blk`  in  1  block-transfer flag (MEMORY mode only).
- `up`  in  1  block direction: 1 = ascending addresses, 0 = descending.
- `reg_list`  in  `NUM_REGS`  block register list.
- `MEM_r_en`, `MEM_w_en`, `WB_en`, `b`  out  1 each  control enables.
- `s_out`  out  1  flag-update enable.
- `exec_cmd`  out  4  ALU command, from the shared ALU constants.
- `busy`  out  1  holds IF/ID (PC write and IF/ID load disabled).
- `uop_reg`  out  `REG_IDX_W`  Rd/Rt override for the current micro-op.
- `uop_offset`  out  `OFS_W`  unsigned byte offset added to or subtracted from Rn.
- `uop_valid`  out  1  outputs describe a block micro-op; EX selects `uop_offset` instead of Val2.
- `last_uop`  out  1  final micro-op of a block.

## Operation
- **States:** `IDLE` and `XFER`. Reset (`rst`=0) forces `IDLE`, clears the pending list and zeroes the offset. All outputs are then 0, with `exec_cmd` = NOP_ALU_CMD.
- **`IDLE`, non-block instruction:** purely combinational legacy decode.
  - Arithmetic ops MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR set `WB_en` and map to the same-named ALU command.
  - CMP maps to SUB and TST maps to AND, both without `WB_en`.
  - MEMORY with `blk`=0: `s_in`=1 gives `MEM_r_en`, `WB_en`, ADD. `s_in`=0 gives `MEM_w_en`, ADD.
  - BRANCH sets `b`.
  - `s_out` = `s_in`. Unknown opcode gives NOP with all enables 0.
  - `valid_in`=0 gives all enables 0.
- **`IDLE`, block accept** (`valid_in`, MEMORY, `blk`, `reg_list`≠0, !`freeze`):
  - Latch `reg_list`, `s_in` (as L) and `up`; clear the offset; go to `XFER`.
  - This cycle outputs NOP with all enables 0 and `busy`=1.
- **Block with `reg_list`=0:** NOP with all enables 0; no state change; `busy`=0.
- **`XFER`, each cycle:** issue the micro-op for the lowest set bit of the pending list.
  - `uop_reg` = that bit's index; `uop_offset` = current offset; `uop_valid`=1; `s_out`=0.
  - `exec_cmd` = ADD if `up`, else SUB.
  - L=1 sets `MEM_r_en` and `WB_en`; L=0 sets `MEM_w_en`.
  - If !`freeze` at the clock edge: clear that bit and add `WORD_BYTES` to the offset, wrapping mod 2^`OFS_W`.
- **`last_uop`:** 1 when exactly one bit is pending. On that non-frozen edge the FSM returns to `IDLE`.
- **`busy`:** 1 in the accept cycle and in every `XFER` cycle except the `last_uop` cycle.
- **`freeze` in `XFER`:** state, offset and outputs hold. Enables stay asserted; the pipeline register is frozen, so the micro-op is not duplicated.
- **`freeze` in `IDLE`:** the block accept is deferred until `freeze`=0.
- **Inputs during `XFER`:** `mode`, `op_code`, `blk` and `reg_list` are ignored.

## Timing
- Non-block decode: 0-cycle combinational latency, identical to the legacy unit.
- Block with N set bits: 1 accept cycle plus N issue cycles, extended 1:1 by frozen cycles.
- The next instruction is decoded in the cycle after `last_uop`.
- Reset asserted mid-`XFER` aborts immediately, asynchronously. The remaining list is dropped and no further micro-ops issue.
- After reset release, the first rising edge sees `IDLE`.

## Test plan
- **Legacy decode sweep:** all 11 opcodes and both memory L values with `blk`=0.
  - Enables and `exec_cmd` match the legacy mapping.
  - CMP: `WB_en`=0, `exec_cmd`=SUB.
  - `busy`=0 throughout.
- **LDM, ascending:** `reg_list`=0x0085, `s_in`=1, `up`=1.
  - Accept cycle: NOP, `busy`=1.
  - Then 3 cycles: `uop_reg` 0, 2, 7 with offsets 0, 4, 8.
  - `MEM_r_en`=`WB_en`=1 and `exec_cmd`=ADD on all three; `last_uop` only on reg 7; `busy`=0 on that cycle.
- **STM, descending, with freeze:** `reg_list`=0xC000, `s_in`=0, `up`=0; `freeze` held for 2 cycles during the reg-14 issue.
  - Reg 14 is held 3 cycles at offset 0, then reg 15 at offset 4.
  - `MEM_w_en`=1 and `exec_cmd`=SUB throughout.
- **Empty list:** block instruction with `reg_list`=0 gives NOP, `busy`=0, and no `XFER` entry.
- **Reset mid-block:** `reg_list`=0xFFFF; pull `rst` low after 5 micro-ops.
  - Outputs go to 0 / NOP immediately.
  - After release, a following ADD decodes normally with `WB_en`=1.
- **Full list, `NUM_REGS`=16:** `reg_list`=0xFFFF gives 16 micro-ops, offsets 0 to 60, then `IDLE`.
